// File: rtl/dram_dump_pkg.sv
// Shared types and constants for the DRAM read-back UART dumper.
package dram_dump_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    CAP  = 3'd2,
    LO   = 3'd3,
    HI   = 3'd4,
    FIN  = 3'd5
  } state_t;

  localparam int          ADDR_W     = 5;
  localparam int          DATA_W     = 16;
  localparam logic [4:0]  LAST_ADDR  = 5'd31;
  localparam int          FRAME_BITS = 10;

  // Build an 8N1 frame, bit 0 goes out first: start(0), data LSB..MSB, stop(1).
  function automatic logic [FRAME_BITS-1:0] uart_frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 UART transmitter. Owns the baud counter and bit index;
// ready is asserted while idle and on the last cycle of the stop bit so a
// new load can follow with no idle gap.
module uart_tx_byte
  import dram_dump_pkg::*;
#(
  parameter int CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int                BAUD_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [3:0]        LAST_BIT  = 4'(FRAME_BITS - 1);

  logic                  r_active;
  logic [BAUD_W-1:0]     r_baud;
  logic [3:0]            r_bit;
  logic [FRAME_BITS-1:0] r_shift;
  logic                  r_tx;
  logic                  w_bit_end;
  logic                  w_frame_end;

  assign w_bit_end   = r_active && (r_baud == BAUD_LAST);
  assign w_frame_end = w_bit_end && (r_bit == LAST_BIT);
  assign ready       = !r_active || w_frame_end;
  assign tx          = r_tx;

  // Frame sequencing: load a new frame, advance bits, or return to idle-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= 1'b0;
      r_baud   <= '0;
      r_bit    <= 4'd0;
      r_shift  <= '1;
      r_tx     <= 1'b1;
    end else if (load && ready) begin
      r_active <= 1'b1;
      r_baud   <= '0;
      r_bit    <= 4'd0;
      r_shift  <= uart_frame(data);
      r_tx     <= 1'b0;
    end else if (w_frame_end) begin
      r_active <= 1'b0;
      r_baud   <= '0;
      r_bit    <= 4'd0;
      r_tx     <= 1'b1;
    end else if (w_bit_end) begin
      r_baud   <= '0;
      r_bit    <= r_bit + 4'd1;
      r_shift  <= {1'b1, r_shift[FRAME_BITS-1:1]};
      r_tx     <= r_shift[1];
    end else if (r_active) begin
      r_baud   <= r_baud + BAUD_W'(1'b1);
    end else begin
      r_baud   <= r_baud;
    end
  end

endmodule

// File: rtl/dram_dump_uart_tx.sv
// Walks DRAM read addresses 0..31 and streams a sync byte followed by each
// 16-bit word (low byte first) out of the UART tx pin.
module dram_dump_uart_tx
  import dram_dump_pkg::*;
#(
  parameter int         CLK_DIV   = 868,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [DATA_W-1:0]   r_ram_data_q;
  logic [DATA_W-1:0]   w_data_nxt;
  logic                w_load;
  logic [7:0]          w_byte;
  logic                w_ready;
  logic                w_tx;
  logic                r_busy;
  logic                r_done;

  uart_tx_byte #(
    .CLK_DIV (CLK_DIV)
  ) u_uart (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .data  (w_byte),
    .tx    (w_tx),
    .ready (w_ready)
  );

  // Next-state, address and byte-select logic. The low byte is loaded
  // straight from the DRAM in CAP, the same value that is latched there.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_ram_data_q;
    w_load      = 1'b0;
    w_byte      = 8'h00;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SYNC;
          w_addr_nxt  = '0;
          w_load      = 1'b1;
          w_byte      = SYNC_BYTE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SYNC: begin
        if (w_ready) begin
          w_state_nxt = CAP;
        end else begin
          w_state_nxt = SYNC;
        end
      end
      CAP: begin
        w_data_nxt  = ram_rdata;
        w_load      = 1'b1;
        w_byte      = ram_rdata[7:0];
        w_state_nxt = LO;
      end
      LO: begin
        if (w_ready) begin
          w_load      = 1'b1;
          w_byte      = r_ram_data_q[15:8];
          w_state_nxt = HI;
        end else begin
          w_state_nxt = LO;
        end
      end
      HI: begin
        if (w_ready) begin
          if (r_addr == LAST_ADDR) begin
            w_state_nxt = FIN;
          end else begin
            w_addr_nxt  = r_addr + 5'd1;
            w_state_nxt = CAP;
          end
        end else begin
          w_state_nxt = HI;
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, address and captured-word registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_ram_data_q <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_ram_data_q <= w_data_nxt;
    end
  end

  // Registered status: busy tracks any non-IDLE state, done marks the FIN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (w_state_nxt == FIN);
    end
  end

  assign ram_addr = r_addr;
  assign busy     = r_busy;
  assign done     = r_done;
  assign tx       = w_tx;

endmodule

// File: tb/tb_dram_dump_uart_tx.sv
// Scoreboard bench for dram_dump_uart_tx with CLK_DIV=4 and a behavioural
// 32x16 async-read memory.
module tb_dram_dump_uart_tx;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  ram_addr;
  logic [15:0] ram_rdata;
  logic        tx;
  logic        busy;
  logic        done;

  logic [15:0] mem [32];
  logic [7:0]  exp_q [$];

  int checks;
  int errors;
  int cyc;
  int s;
  int done_cnt;
  int d;

  bit         dec_active;
  int         dec_cnt;
  logic [7:0] dec_sh;

  assign ram_rdata = mem[ram_addr];

  dram_dump_uart_tx #(
    .CLK_DIV   (4),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: decodes UART frames at negedges and pops expected bytes.
  initial begin
    dec_active = 1'b0;
    dec_cnt    = 0;
    dec_sh     = 8'h00;
    done_cnt   = 0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (rst) begin
        dec_active = 1'b0;
      end else if (!dec_active) begin
        if (tx === 1'b0) begin
          dec_active = 1'b1;
          dec_cnt    = 1;
        end
      end else begin
        if (dec_cnt == 2) begin
          check("start_bit_mid", {31'd0, tx}, 32'd0);
        end else if (dec_cnt >= 6 && dec_cnt <= 34 && ((dec_cnt - 6) % 4) == 0) begin
          dec_sh[(dec_cnt - 6) / 4] = tx;
        end else if (dec_cnt == 38) begin
          check("stop_bit_mid", {31'd0, tx}, 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h expected none", dec_sh);
          end else begin
            check("byte", {24'd0, dec_sh}, {24'd0, exp_q.pop_front()});
          end
          dec_active = 1'b0;
        end
        dec_cnt++;
      end
    end
  end

  task automatic load_mem_pattern();
    logic [7:0] a8;
    for (int a = 0; a < 32; a++) begin
      a8 = 8'(a);
      mem[a] = {a8, ~a8};
    end
  endtask

  // Push the expected stream, pulse start for one cycle, check the first edge.
  task automatic start_dump();
    exp_q.push_back(8'hA5);
    for (int a = 0; a < 32; a++) begin
      exp_q.push_back(mem[a][7:0]);
      exp_q.push_back(mem[a][15:8]);
    end
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    check("first_start_bit_tx", {31'd0, tx}, 32'd0);
    check("busy_rise", {31'd0, busy}, 32'd1);
    check("addr_restart", {27'd0, ram_addr}, 32'd0);
  endtask

  task automatic wait_done();
    d = -1;
    for (int i = 0; i < 3000; i++) begin
      if (done === 1'b1) begin
        d = cyc;
        break;
      end
      @(negedge clk);
    end
    if (d < 0) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("done_latency", d - s, 32'd2633);
    end
  endtask

  function automatic logic exp_tx_s3(input int j);
    logic [7:0] b;
    b = 8'hA5;
    if (j <= 4) return 1'b0;
    if (j <= 36) return b[(j - 5) / 4];
    if (j <= 41) return 1'b1;
    if (j <= 45) return 1'b0;
    if (j <= 49) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    int done_before;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    load_mem_pattern();
    repeat (3) @(negedge clk);
    check("reset_outputs", {24'd0, tx, busy, done, ram_addr}, 32'h80);
    rst = 1'b0;

    // 1. Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", {24'd0, tx, busy, done, ram_addr}, 32'h80);
    end

    // 2. Full dump, mem[a] = {a, ~a}
    start_dump();
    wait_done();
    @(negedge clk);
    check("post_done_status", {29'd0, busy, done, tx}, 32'd1);
    check("addr_hold_31", {27'd0, ram_addr}, 32'd31);
    repeat (5) @(negedge clk);
    check("addr_still_31", {27'd0, ram_addr}, 32'd31);

    // 3. Bit timing with mem[0] = 16'h0001
    mem[0] = 16'h0001;
    start_dump();
    for (int j = 2; j <= 53; j++) begin
      @(negedge clk);
      check("bit_timing", {31'd0, tx}, {31'd0, exp_tx_s3(j)});
    end
    wait_done();
    mem[0] = 16'h00FF;
    repeat (4) @(negedge clk);

    // 4. start re-asserted at cycles 5 and 1000 during a dump
    start_dump();
    while (cyc < s + 5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 1000) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // 6. start during FIN is ignored, start in the next cycle is accepted
    start = 1'b1;
    @(negedge clk);
    start_dump();
    wait_done();
    repeat (4) @(negedge clk);

    // 5. Async reset in the middle of lo7
    start_dump();
    while (cyc < s + 629) @(negedge clk);
    done_before = done_cnt;
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("abort_immediate", {29'd0, tx, busy, done}, 32'd4);
    @(negedge clk);
    check("abort_addr", {27'd0, ram_addr}, 32'd0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_abort_idle", {29'd0, tx, busy, done}, 32'd4);
    end
    check("no_done_on_abort", done_cnt, done_before);
    start_dump();
    wait_done();

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    check("done_pulse_count", done_cnt, 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
